// File: rtl/uart_rx_buffer_if.sv
// Receiver-facing strobes, host read port and status of the rx byte buffer.
// almost_full exists only when UART_RX_BUFFER_WMARK_EN is defined.
interface uart_rx_buffer_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]      Rx_DATA;
    logic            Rx_VALID;
    logic            Rx_PERROR;
    logic            Rx_FERROR;
    logic            rd_en;
    logic            clear;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [ADDR_W:0] count;
    logic            overrun;
    logic [7:0]      perror_cnt;
    logic [7:0]      ferror_cnt;
`ifdef UART_RX_BUFFER_WMARK_EN
    logic            almost_full;
`endif

    modport slave (
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rd_en, clear,
        output rd_data, rd_valid, empty, full, count, overrun, perror_cnt, ferror_cnt
`ifdef UART_RX_BUFFER_WMARK_EN
        , almost_full
`endif
    );

    modport master (
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR, rd_en, clear,
        input  rd_data, rd_valid, empty, full, count, overrun, perror_cnt, ferror_cnt
`ifdef UART_RX_BUFFER_WMARK_EN
        , almost_full
`endif
    );
endinterface

// File: rtl/uart_rx_buffer.sv
// Edge-detects UART receiver strobes into a DEPTH-entry byte FIFO with a 1-cycle registered read,
// sticky overrun and saturating parity/framing counters; UART_RX_BUFFER_WMARK_EN adds registered almost_full.
module uart_rx_buffer #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int WMARK  = 6
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_buffer_if.slave bus
);
    typedef enum logic {IDLE, OUT} rd_state_t;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PTR_ONE = 1;

    if (DEPTH < 2 || DEPTH != (1 << ADDR_W)) begin : g_bad_depth
        $error("uart_rx_buffer: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
    end
    if (WMARK < 1 || WMARK > DEPTH) begin : g_bad_wmark
        $error("uart_rx_buffer: WMARK must lie in 1..DEPTH");
    end

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   count_q, count_nxt;
    logic              rx_valid_q, perror_q, ferror_q;
    logic [7:0]        rd_data_q;
    logic              overrun_q;
    logic [7:0]        perror_cnt_q, ferror_cnt_q;
    rd_state_t         state_q, state_nxt;

    logic wr_evt, perror_evt, ferror_evt;
    logic empty_w, full_w, rd_acc, wr_acc, wr_drop;

    assign wr_evt     = bus.Rx_VALID  & ~rx_valid_q;
    assign perror_evt = bus.Rx_PERROR & ~perror_q;
    assign ferror_evt = bus.Rx_FERROR & ~ferror_q;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == DEPTH_C);
    assign rd_acc  = bus.rd_en & ~empty_w;
    // A read in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign wr_acc  = wr_evt & (~full_w | rd_acc);
    assign wr_drop = wr_evt & ~wr_acc;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_ONE;
            2'b01:   count_nxt = count_q - CNT_ONE;
            default: count_nxt = count_q;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    state_nxt = rd_acc ? OUT : IDLE;
            OUT:     state_nxt = rd_acc ? OUT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.Rx_DATA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            rd_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            perror_q   <= 1'b0;
            ferror_q   <= 1'b0;
        end else begin
            rx_valid_q <= bus.Rx_VALID;
            perror_q   <= bus.Rx_PERROR;
            ferror_q   <= bus.Rx_FERROR;
            count_q    <= count_nxt;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_data_q <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + PTR_ONE;
            end
        end
    end

    // clear wins over any same-cycle increment or overrun set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q    <= 1'b0;
            perror_cnt_q <= 8'h00;
            ferror_cnt_q <= 8'h00;
        end else if (bus.clear) begin
            overrun_q    <= 1'b0;
            perror_cnt_q <= 8'h00;
            ferror_cnt_q <= 8'h00;
        end else begin
            if (wr_drop) begin
                overrun_q <= 1'b1;
            end
            if (perror_evt && perror_cnt_q != 8'hFF) begin
                perror_cnt_q <= perror_cnt_q + 8'd1;
            end
            if (ferror_evt && ferror_cnt_q != 8'hFF) begin
                ferror_cnt_q <= ferror_cnt_q + 8'd1;
            end
        end
    end

`ifdef UART_RX_BUFFER_WMARK_EN
    localparam logic [ADDR_W:0] WMARK_C = (ADDR_W+1)'(WMARK);
    logic almost_full_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (count_nxt >= WMARK_C);
        end
    end

    assign bus.almost_full = almost_full_q;
`endif

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = (state_q == OUT);
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.count      = count_q;
    assign bus.overrun    = overrun_q;
    assign bus.perror_cnt = perror_cnt_q;
    assign bus.ferror_cnt = ferror_cnt_q;
endmodule
